motion_sequencer: RTL and testbench
===================================

Name: motion_sequencer

Overview:
Controller for the bouncing-logo position datapath and the sound generator. It paces the datapath by issuing one-cycle step strobes locked to the frame rate, at a user-adjustable speed level. It also turns the datapath's bounce events into timed ping/pong/go tone commands, so sounds never overlap or get lost.

Parameters:
SPEED_MIN, 1, lowest speed level (1 step every SPEED_MAX+1-SPEED_MIN frames)
SPEED_MAX, 15, highest speed level (1 step every frame); must be below 16
SPEED_INIT, 8, speed level after reset
TONE_CYCLES, 2500000, clk cycles a tone is held (100 ms at 25 MHz)
GAP_CYCLES, 250000, muted clk cycles after each tone

Ports:
clk  in  1  system clock
clr  in  1  reset, synchronous, active-high
vsync_start  in  1  one-cycle pulse at start of vertical blank
inc_vel  in  1  speed-up button, debounced level
dec_vel  in  1  slow-down button, debounced level
hit_x  in  1  one-cycle pulse: datapath reversed x direction
hit_y  in  1  one-cycle pulse: datapath reversed y direction
step  out  1  one-cycle pulse: datapath advances x_logo/y_logo once
speed  out  4  current speed level
mute  out  1  1 = sound generator silent
code_sound  out  2  00 stop, 01 pong, 10 ping, 11 go

Behaviour:
- Reset: clr is sampled on the clk edge only and overrides all other inputs.
- Reset values: step=0, speed=SPEED_INIT, mute=0, code_sound=11 (go), sound FSM=PLAY, tone counter=0, frame counter=0, pending flags clear, button edge registers = current button levels (a button held through reset does not count as a press).
- Speed control:
  - A rising edge on inc_vel (level 1, previous sample 0) increments speed, saturating at SPEED_MAX.
  - A rising edge on dec_vel decrements speed, saturating at SPEED_MIN.
  - Both rising edges in the same cycle: no change.
  - A held button produces one change only.
- Step pacing:
  - period = SPEED_MAX+1-speed, a value from 1 to SPEED_MAX.
  - On each vsync_start: if frame_cnt >= period-1, frame_cnt<=0 and step pulses on the next cycle (latency 1); otherwise frame_cnt increments.
  - The >= comparison means a speed increase takes effect at the next vsync with no stall.
  - step is never high on two consecutive cycles.
  - No step is issued without a vsync_start.
- Sound FSM states: IDLE, PLAY, GAP.
  - IDLE: mute=1, code_sound=00. When a hit arrives, or a flag is pending, go to PLAY with the chosen code and clear the tone counter.
  - PLAY: mute=0, code_sound holds the chosen code. After TONE_CYCLES cycles, go to GAP.
  - GAP: mute=1, code_sound=00 for GAP_CYCLES cycles, then go to PLAY if any flag is pending, else IDLE.
- Code selection priority: ping (hit_y / pending_y) over pong (hit_x / pending_x). The consumed flag clears when its tone starts.
- Pending flags:
  - pending_x and pending_y are one bit each. A hit while in PLAY or GAP sets its flag.
  - A repeat hit of the same axis while its flag is already set is absorbed (no counting).
  - hit_x and hit_y in the same cycle while IDLE: play ping and set pending_x.
  - A hit in the same cycle the FSM consumes that flag sets it again.
- Reset mid-tone: abandon the current tone, clear pending flags, restart the go tone with a fresh full TONE_CYCLES.
- Counters are sized from TONE_CYCLES and GAP_CYCLES and must not wrap before terminal count.

Test Plan:
1. TONE_CYCLES=8, GAP_CYCLES=2: release clr -> code_sound=11, mute=0 for 8 cycles; then mute=1, code=00 for 2 cycles; then IDLE (mute=1).
2. speed=15, vsync_start every 10 cycles -> step one cycle after every vsync. Apply 7 dec_vel presses -> speed=8, step after every 8th vsync. Apply 20 inc presses -> speed saturates at 15. Simultaneous inc and dec edge -> speed unchanged.
3. Hold inc_vel high for 100 cycles -> speed increases by exactly 1. Assert inc_vel during clr and release it after clr -> no change.
4. IDLE, hit_x and hit_y in the same cycle -> 10 for 8 cycles, gap of 2, 01 for 8 cycles, gap, IDLE.
5. During a pong tone, apply 3 hit_x pulses and 1 hit_y -> after the gap exactly one ping, then exactly one pong, then IDLE.
6. Assert clr at cycle 4 of a ping tone -> next cycle code=11, mute=0, full 8-cycle go tone, no pending tones follow.

Source files
------------

// File: rtl/motion_sequencer.sv
// Frame-locked step pacing with adjustable speed, plus the tone scheduler that turns
// bounce events into non-overlapping ping/pong/go commands for the sound generator.
module motion_sequencer #(
  parameter int unsigned SPEED_MIN   = 1,
  parameter int unsigned SPEED_MAX   = 15,
  parameter int unsigned SPEED_INIT  = 8,
  parameter int unsigned TONE_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       vsync_start,
  input  logic       inc_vel,
  input  logic       dec_vel,
  input  logic       hit_x,
  input  logic       hit_y,
  output logic       step,
  output logic [3:0] speed,
  output logic       mute,
  output logic [1:0] code_sound
);

  localparam int unsigned SPEED_W = 4;
  localparam int unsigned CNT_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] CODE_STOP = 2'b00;
  localparam logic [1:0] CODE_PONG = 2'b01;
  localparam logic [1:0] CODE_PING = 2'b10;
  localparam logic [1:0] CODE_GO   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  // Speed level from button rising edges; a button held through reset is not a press
  logic inc_q, dec_q;
  logic inc_edge, dec_edge;

  assign inc_edge = inc_vel & ~inc_q;
  assign dec_edge = dec_vel & ~dec_q;

  always_ff @(posedge clk) begin
    inc_q <= inc_vel;
    dec_q <= dec_vel;
    if (clr) begin
      speed <= SPEED_W'(SPEED_INIT);
    end else if (inc_edge && !dec_edge && speed < SPEED_W'(SPEED_MAX)) begin
      speed <= speed + SPEED_W'(1);
    end else if (dec_edge && !inc_edge && speed > SPEED_W'(SPEED_MIN)) begin
      speed <= speed - SPEED_W'(1);
    end
  end

  // Step pacing: one step every (SPEED_MAX+1-speed) vsyncs, never on back-to-back cycles
  logic [SPEED_W-1:0] frame_cnt;
  logic [SPEED_W-1:0] period_m1;

  assign period_m1 = SPEED_W'(SPEED_MAX) - speed;

  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt <= '0;
      step      <= 1'b0;
    end else begin
      step <= 1'b0;
      if (vsync_start) begin
        if (frame_cnt >= period_m1) begin
          frame_cnt <= '0;
          step      <= ~step;
        end else begin
          frame_cnt <= frame_cnt + SPEED_W'(1);
        end
      end
    end
  end

  // Sound scheduler
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             pend_x, pend_y, pend_x_d, pend_y_d;
  logic             mute_d;
  logic [1:0]       code_sound_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_PLAY;
      cnt        <= '0;
      code_q     <= CODE_GO;
      pend_x     <= 1'b0;
      pend_y     <= 1'b0;
      mute       <= 1'b0;
      code_sound <= CODE_GO;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      code_q     <= code_d;
      pend_x     <= pend_x_d;
      pend_y     <= pend_y_d;
      mute       <= mute_d;
      code_sound <= code_sound_d;
    end
  end

  // Next state: a starting tone consumes the ping request first, re-arming on a same-cycle hit
  always_comb begin
    logic start;
    logic req_x, req_y;
    state_d  = state;
    cnt_d    = cnt + CNT_W'(1);
    code_d   = code_q;
    pend_x_d = pend_x;
    pend_y_d = pend_y;
    start    = 1'b0;
    req_x    = hit_x | pend_x;
    req_y    = hit_y | pend_y;
    case (state)
      S_IDLE: begin
        cnt_d = cnt;
        if (req_x || req_y) start = 1'b1;
      end
      S_PLAY: begin
        pend_x_d = pend_x | hit_x;
        pend_y_d = pend_y | hit_y;
        if (cnt == TONE_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        pend_x_d = pend_x | hit_x;
        pend_y_d = pend_y | hit_y;
        if (cnt == GAP_LAST) begin
          if (pend_x || pend_y) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (start) begin
      state_d = S_PLAY;
      cnt_d   = '0;
      if (req_y) begin
        code_d   = CODE_PING;
        pend_y_d = pend_y & hit_y;
        pend_x_d = pend_x | hit_x;
      end else begin
        code_d   = CODE_PONG;
        pend_x_d = pend_x & hit_x;
        pend_y_d = pend_y | hit_y;
      end
    end
  end

  // Outputs follow the next state so they are registered alongside it
  always_comb begin
    mute_d       = 1'b1;
    code_sound_d = CODE_STOP;
    if (state_d == S_PLAY) begin
      mute_d       = 1'b0;
      code_sound_d = code_d;
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Randomized and directed bench for motion_sequencer; a tone/step scheduler model
// pushes expected outputs per cycle and a monitor compares them against the DUT.
module tb_motion_sequencer;

  localparam int SPEED_MIN   = 1;
  localparam int SPEED_MAX   = 15;
  localparam int SPEED_INIT  = 8;
  localparam int TONE_CYCLES = 8;
  localparam int GAP_CYCLES  = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       vsync_start = 1'b0;
  logic       inc_vel = 1'b0;
  logic       dec_vel = 1'b0;
  logic       hit_x = 1'b0;
  logic       hit_y = 1'b0;
  logic       step;
  logic [3:0] speed;
  logic       mute;
  logic [1:0] code_sound;

  motion_sequencer #(
    .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX), .SPEED_INIT(SPEED_INIT),
    .TONE_CYCLES(TONE_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .vsync_start(vsync_start), .inc_vel(inc_vel),
    .dec_vel(dec_vel), .hit_x(hit_x), .hit_y(hit_y), .step(step),
    .speed(speed), .mute(mute), .code_sound(code_sound)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       step;
    logic [3:0] speed;
    logic       mute;
    logic [1:0] code;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: tone phase 0=silent, 1=sounding, 2=gap; left = cycles remaining in phase
  int m_speed, m_frames, m_phase, m_left, m_code;
  bit m_step, m_inc_prev, m_dec_prev, m_px, m_py;
  bit b_inc = 1'b0, b_dec = 1'b0;

  task automatic start_tone(input bit hx, input bit hy);
    if (hy || m_py) begin
      m_code = 2;
      m_py   = m_py && hy;
      m_px   = m_px || hx;
    end else begin
      m_code = 1;
      m_px   = m_px && hx;
      m_py   = m_py || hy;
    end
    m_phase = 1;
    m_left  = TONE_CYCLES;
  endtask

  task automatic model_step(input bit c, input bit v, input bit hx, input bit hy);
    int period;
    bit ns;
    bit ie, de;
    exp_t e;
    if (c) begin
      m_speed = SPEED_INIT; m_frames = 0; m_step = 0;
      m_phase = 1; m_left = TONE_CYCLES; m_code = 3; m_px = 0; m_py = 0;
    end else begin
      period = SPEED_MAX + 1 - m_speed;
      ns = 0;
      if (v) begin
        if (m_frames + 1 >= period) begin
          m_frames = 0;
          ns = !m_step;
        end else begin
          m_frames++;
        end
      end
      m_step = ns;
      ie = b_inc && !m_inc_prev;
      de = b_dec && !m_dec_prev;
      if (ie && !de && m_speed < SPEED_MAX) m_speed++;
      else if (de && !ie && m_speed > SPEED_MIN) m_speed--;
      case (m_phase)
        0: if (hx || hy || m_px || m_py) start_tone(hx, hy);
        1: begin
          m_px = m_px || hx;
          m_py = m_py || hy;
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = GAP_CYCLES; end
        end
        default: begin
          m_left--;
          if (m_left == 0 && (m_px || m_py)) begin
            start_tone(hx, hy);
          end else begin
            m_px = m_px || hx;
            m_py = m_py || hy;
            if (m_left == 0) m_phase = 0;
          end
        end
      endcase
    end
    m_inc_prev = b_inc;
    m_dec_prev = b_dec;
    e.step  = m_step;
    e.speed = 4'(m_speed);
    e.mute  = (m_phase != 1);
    e.code  = (m_phase == 1) ? 2'(m_code) : 2'b00;
    sb_q.push_back(e);
  endtask

  task automatic tick(input bit c, input bit v, input bit hx, input bit hy);
    @(negedge clk); #1;
    clr = c; vsync_start = v; hit_x = hx; hit_y = hy;
    inc_vel = b_inc; dec_vel = b_dec;
    model_step(c, v, hx, hy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 1, 0, 0);
      idle(9);
    end
  endtask

  task automatic press(input bit up, input bit down);
    b_inc = up; b_dec = down;
    idle(2);
    b_inc = 0; b_dec = 0;
    idle(1);
  endtask

  // Monitor: one popped expectation per cycle, compared field by field
  always @(negedge clk) begin
    cyc++;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      checks++;
      if (step !== cur.step) begin
        errors++;
        $display("FAIL step cyc=%0d got=%b want=%b", cyc, step, cur.step);
      end
      checks++;
      if (speed !== cur.speed) begin
        errors++;
        $display("FAIL speed cyc=%0d got=%0d want=%0d", cyc, speed, cur.speed);
      end
      checks++;
      if (mute !== cur.mute || code_sound !== cur.code) begin
        errors++;
        $display("FAIL sound cyc=%0d got mute=%b code=%b want mute=%b code=%b",
                 cyc, mute, code_sound, cur.mute, cur.code);
      end
    end
  end

  initial begin
    // Reset, then go tone, gap and silence
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    idle(14);
    // Speed to max, then 7 slow-downs, saturation and simultaneous presses
    for (int i = 0; i < 7; i++) press(1, 0);
    frames(4);
    for (int i = 0; i < 7; i++) press(0, 1);
    frames(17);
    for (int i = 0; i < 20; i++) press(1, 0);
    frames(3);
    press(1, 1);
    for (int i = 0; i < 20; i++) press(0, 1);
    frames(3);
    // Held button gives one change; button held through reset is not a press
    b_inc = 1; idle(100); b_inc = 0; idle(2);
    b_inc = 1; tick(1, 0, 0, 0); tick(1, 0, 0, 0); idle(5); b_inc = 0;
    idle(12);
    // Simultaneous hits while silent: ping then pong
    tick(0, 0, 1, 1);
    idle(30);
    // Repeated x hits absorbed during a pong, one y hit queued
    tick(0, 0, 1, 0); idle(2);
    tick(0, 0, 1, 0); idle(1); tick(0, 0, 1, 0); tick(0, 0, 0, 1); tick(0, 0, 1, 0);
    idle(40);
    // Reset four cycles into a ping with a pong queued
    tick(0, 0, 0, 1); idle(1); tick(0, 0, 1, 0); idle(1);
    tick(1, 0, 0, 0);
    idle(20);
    // Random mix, including hits landing on gap boundaries
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) b_inc = ~b_inc;
      if ($urandom_range(0, 29) == 0) b_dec = ~b_dec;
      tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 14) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(3);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending expectations", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
